// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state encodings for the UART receive front end.
package uart_pkg;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DATA_BITS  = 8;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;
  function automatic int mid_tick(input int os);
    return os / 2 - 1;
  endfunction
  localparam int MID_TICK = mid_tick(DEF_OVERSAMPLE);
endpackage

// File: rtl/uart_rx_frontend_if.sv
// uart_rx_frontend_if: character handshake and status between the receiver and the receive buffer.
interface uart_rx_frontend_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] rbr;
  logic newdata;
  logic ack;
  logic rfd;
  logic frame_err;
  logic overrun;
  modport master (output rbr, newdata, frame_err, overrun, input ack, rfd);
  modport slave  (input rbr, newdata, frame_err, overrun, output ack, rfd);
endinterface

// File: rtl/bit_sync.sv
// bit_sync: multi-stage synchroniser for an asynchronous input, resetting to 1 (idle line level).
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[STAGES-2:0], d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '1;
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: 16x-oversampled 8N1 deframer with newdata/ack/rfd handoff and error pulses.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic rcvbuf_clk,
  input  logic rst_n,
  input  logic rxd,
  output logic rx_busy,
  uart_rx_frontend_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID  = TW'(mid_tick(OVERSAMPLE));
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  logic rxs;
  logic [2:0] state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, rbr_q, rbr_d;
  logic done_q, done_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic newdata_q, newdata_d, pending_q, pending_d;
  logic accept, raise;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(rcvbuf_clk), .rst_n(rst_n), .d(rxd), .q(rxs));

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tick_d  = '0;
        state_d = rxs ? S_IDLE : S_START;
      end
      S_START: if (tick_q == MID) begin
        state_d = rxs ? S_IDLE : S_DATA;
        tick_d  = '0;
        bit_d   = '0;
      end
      S_DATA: if (tick_q == LAST) begin
        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
        bit_d   = bit_q + 3'd1;
        state_d = (bit_q == 3'(DATA_BITS - 1)) ? S_STOP : S_DATA;
      end
      S_STOP: if (tick_q == LAST) begin
        state_d = rxs ? S_IDLE : S_BREAK;
        done_d  = rxs;
        ferr_d  = ~rxs;
      end
      S_BREAK: state_d = rxs ? S_IDLE : S_BREAK;
      default: state_d = S_IDLE;
    endcase
  end

  // A held ack keeps the character parked in pending so it cannot be consumed by a stale ack.
  always_comb begin
    accept    = done_q & ~pending_q & (~newdata_q | bus.ack);
    raise     = bus.rfd & ~bus.ack;
    rbr_d     = accept ? shift_q : rbr_q;
    newdata_d = (accept | pending_q) ? raise : newdata_q & ~bus.ack;
    pending_d = accept ? ~raise : pending_q & ~raise;
    ovr_d     = done_q & ~accept;
  end

  always_ff @(posedge rcvbuf_clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rbr_q     <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      newdata_q <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      rbr_q     <= rbr_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      newdata_q <= newdata_d;
      pending_q <= pending_d;
    end

  assign bus.rbr       = rbr_q;
  assign bus.newdata   = newdata_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
  assign rx_busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed 8N1 frames against hand-computed receive, handshake and error results.
module tb_uart_rx_frontend;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rxd = 1'b1;
  logic rx_busy;
  int n_tests = 0, n_fail = 0;
  int ecnt = 0, start_e = 0, rise_e = 0;
  int ferr_cnt = 0, ovr_cnt = 0, rise_cnt = 0;
  int f0, o0, r0;
  logic nd_prev = 1'b0;

  uart_rx_frontend_if #(.DATA_BITS(8)) bus ();
  uart_rx_frontend dut (.rcvbuf_clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_busy(rx_busy), .bus(bus));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    ecnt++;
    if (bus.frame_err) ferr_cnt++;
    if (bus.overrun) ovr_cnt++;
    if (bus.newdata && !nd_prev) begin
      rise_cnt++;
      rise_e = ecnt;
    end
    nd_prev = bus.newdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rxd = 1'b0;
    start_e = ecnt;
    wait_clk(16);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_clk(16);
    end
    rxd = stop;
    wait_clk(16);
  endtask

  task automatic ack_pulse();
    bus.ack = 1'b1;
    wait_clk(1);
    bus.ack = 1'b0;
  endtask

  initial begin
    bus.ack = 1'b0;
    bus.rfd = 1'b1;
    wait_clk(3);
    check("reset_rbr", 32'(bus.rbr), 0);
    check("reset_newdata", 32'(bus.newdata), 0);
    check("reset_ferr", 32'(bus.frame_err), 0);
    check("reset_ovr", 32'(bus.overrun), 0);
    check("reset_busy", 32'(rx_busy), 0);
    rst_n = 1'b1;
    wait_clk(5);

    send_byte(8'hA5, 1'b1);
    check("a5_rbr", 32'(bus.rbr), 32'hA5);
    check("a5_newdata", 32'(bus.newdata), 1);
    check("a5_latency", 32'(rise_e - start_e), 156);
    check("a5_ferr", 32'(ferr_cnt), 0);
    check("a5_busy", 32'(rx_busy), 0);

    ack_pulse();
    check("ack_clear", 32'(bus.newdata), 0);
    send_byte(8'h3C, 1'b1);
    check("3c_rbr", 32'(bus.rbr), 32'h3C);
    check("3c_newdata", 32'(bus.newdata), 1);
    ack_pulse();
    check("3c_clear", 32'(bus.newdata), 0);

    r0 = rise_cnt;
    rxd = 1'b0;
    wait_clk(4);
    rxd = 1'b1;
    wait_clk(2);
    check("glitch_busy", 32'(rx_busy), 1);
    wait_clk(20);
    check("glitch_idle", 32'(rx_busy), 0);
    check("glitch_rbr", 32'(bus.rbr), 32'h3C);
    check("glitch_newdata", 32'(bus.newdata), 0);
    check("glitch_rise", 32'(rise_cnt - r0), 0);

    f0 = ferr_cnt;
    send_byte(8'h81, 1'b0);
    wait_clk(40);
    check("brk_ferr", 32'(ferr_cnt - f0), 1);
    check("brk_newdata", 32'(bus.newdata), 0);
    check("brk_busy", 32'(rx_busy), 1);
    check("brk_rbr", 32'(bus.rbr), 32'h3C);
    rxd = 1'b1;
    wait_clk(20);
    check("brk_idle", 32'(rx_busy), 0);
    check("brk_ferr_once", 32'(ferr_cnt - f0), 1);
    check("brk_rise", 32'(rise_cnt - r0), 0);

    o0 = ovr_cnt;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check("ovr_rbr", 32'(bus.rbr), 32'h11);
    check("ovr_pulse", 32'(ovr_cnt - o0), 1);
    check("ovr_newdata", 32'(bus.newdata), 1);
    ack_pulse();
    check("ovr_clear", 32'(bus.newdata), 0);

    bus.rfd = 1'b0;
    send_byte(8'h5A, 1'b1);
    check("rfd_rbr", 32'(bus.rbr), 32'h5A);
    check("rfd_newdata_low", 32'(bus.newdata), 0);
    bus.rfd = 1'b1;
    wait_clk(1);
    check("rfd_newdata_high", 32'(bus.newdata), 1);

    o0 = ovr_cnt;
    f0 = ferr_cnt;
    rxd = 1'b0;
    wait_clk(16);
    rxd = 1'b1;
    wait_clk(40);
    check("rst_busy_before", 32'(rx_busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst_rbr", 32'(bus.rbr), 0);
    check("rst_newdata", 32'(bus.newdata), 0);
    check("rst_busy", 32'(rx_busy), 0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    send_byte(8'h42, 1'b1);
    check("42_rbr", 32'(bus.rbr), 32'h42);
    check("42_newdata", 32'(bus.newdata), 1);
    check("42_errs", 32'((ferr_cnt - f0) + (ovr_cnt - o0)), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- RS-232 receive front end, directly upstream of the 10K-bit receive buffer.
- Oversamples the asynchronous serial line at 16x the bit rate and deframes 8N1 characters.
- Presents each character on an 8-bit receive buffer register with a newdata/ack/rfd handshake to the downstream buffer.
- Flags framing and overrun errors.
- Runs on the same 16x clock as the receive buffer's control logic, so ack and rfd are synchronous to it.

Parameters:
- OVERSAMPLE, 16, clock ticks per serial bit; power of 2, at least 8.
- DATA_BITS, 8, data bits per character, LSB first.
- SYNC_STAGES, 2, flip-flop stages synchronising rxd.

Ports:
- rcvbuf_clk  in  1  16x bit-rate clock (same clock as the receive buffer).
- rst_n  in  1  reset, asynchronous, active-low.
- rxd  in  1  raw serial line; idles high.
- ack  in  1  from the downstream buffer; high = character taken.
- rfd  in  1  from the downstream buffer; high = ready for data.
- rbr  out  DATA_BITS  received character register.
- newdata  out  1  high = rbr holds an untaken character.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  one-cycle pulse when a character is dropped.
- rx_busy  out  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset: the only clock is rcvbuf_clk and rst_n is asynchronous, active-low. On reset:
  - rbr=0, newdata=0, frame_err=0, overrun=0, rx_busy=0.
  - State=IDLE, tick counter=0, bit counter=0, pending=0.
  - Synchroniser stages reset to 1.
- Reset mid-frame abandons the frame. No error pulses are generated.
- rxs is rxd after SYNC_STAGES flops. All decisions below use rxs.
- Tick counter is log2(OVERSAMPLE) bits and wraps naturally. Bit counter is 3 bits.
- States:
  - IDLE: if rxs==0, go to START with tick=0.
  - START: increment tick. At tick==OVERSAMPLE/2-1 (7), this is mid start bit:
    - rxs==0: go to DATA with tick=0 and bit=0.
    - rxs==1: false start (glitch), back to IDLE with no output.
  - DATA: increment tick. At tick==OVERSAMPLE-1 (15), sample rxs into shift[MSB], right-shift, bit++.
    - After the DATA_BITS-th sample, go to STOP with tick=0.
  - STOP: at tick==15, sample the stop bit.
    - rxs==1: character valid. Load rbr from shift next cycle. Go to IDLE.
    - rxs==0: pulse frame_err for 1 cycle, discard the character, go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. This prevents a held-low line from re-triggering.
- Timing:
  - Start-edge to mid-start latency is SYNC_STAGES+8 clocks.
  - A valid frame loads rbr 1 clock after the stop sample.
- Handshake:
  - On a valid stop, if newdata==0 and pending==0:
    - If rfd==1, load rbr and set newdata=1 on the same edge.
    - If rfd==0, load rbr, set pending=1 and keep newdata=0.
  - pending and rfd==1 and ack==0: newdata=1, pending=0.
  - newdata and ack high: clear newdata next clock. ack is level-sensitive.
  - newdata is not re-raised while ack remains high.
  - rbr is stable whenever newdata==1 or pending==1.
- Overrun:
  - A valid stop while newdata==1 or pending==1 pulses overrun for 1 cycle and drops the new character.
  - rbr keeps the old value.
- Simultaneous events:
  - ack clearing newdata on the same clock as a new valid stop: no overrun. The new character is loaded and follows the normal rfd rule.
- Never more than one character is held.

Decomposition:
- Shared package (uart_pkg):
  - State enum: IDLE, START, DATA, STOP, BREAK.
  - OVERSAMPLE and DATA_BITS defaults.
  - Mid-bit constant OVERSAMPLE/2-1.
- One natural sub-module: bit_sync, a SYNC_STAGES-deep synchroniser with async active-low reset to 1. It is reusable for other asynchronous inputs.
- The FSM, counters and handshake live in uart_rx_frontend.

Test Plan:
- Send 0xA5 (8N1, 16 clocks/bit) with rfd=1 and ack=0 → rbr=0xA5; newdata rises 1 clock after the stop-bit sample; frame_err=0.
- With newdata=1, raise ack for 1 cycle → newdata=0 the next clock. Send 0x3C → rbr=0x3C, newdata=1.
- Drive rxd low for 4 clocks only → no state beyond START; rbr unchanged; newdata stays 0.
- Send 0x81 with the stop bit low, then hold rxd low for 40 clocks → one frame_err pulse; newdata=0; no second reception until rxd goes high.
- Send 0x11 then 0x22 with ack held 0 → rbr=0x11; one overrun pulse at the 0x22 stop; newdata stays 1.
- Hold rfd=0 and send 0x5A → newdata=0 and rbr=0x5A. Raise rfd → newdata=1 next clock.
- Assert rst_n=0 mid-data-bit of 0xFF → all outputs 0 immediately. Release reset and send 0x42 → clean reception of 0x42.
